// File: rtl/pow_share_arb.sv
// Round-robin front end sharing one get_pow (one-hot -> bit index) unit between
// N_REQ requesters; results return tagged with the requester id on a valid/ready channel.

module get_pow #(
  parameter int unsigned W  = 8,
  parameter int unsigned PW = 3
) (
  input  logic [W-1:0]  number,
  output logic [PW-1:0] pow
);

  always_comb begin
    pow = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (number[i]) pow = PW'(i);
    end
  end

endmodule

module pow_share_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned PW    = 3,
  parameter int unsigned IW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_number,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [PW-1:0]      rsp_pow,
  output logic               rsp_err
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [W-1:0]    op_q, op_d;
  logic            valid_q, valid_d;
  logic [IW-1:0]   rid_q, rid_d;
  logic [PW-1:0]   pow_q, pow_d;
  logic            err_q, err_d;

  logic            found;
  logic [IW-1:0]   grant;
  logic [PW-1:0]   gp_pow;
  logic            op_err;
  logic [W-1:0]    num_a [N_REQ];

  get_pow #(.W(W), .PW(PW)) u_get_pow (
    .number (op_q),
    .pow    (gp_pow)
  );

  // Search starts at rr_q and wraps, so the first hit is the round-robin winner.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[IW'((32'(rr_q) + k) % N_REQ)]) begin
        found = 1'b1;
        grant = IW'((32'(rr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      num_a[k] = req_number[k*W +: W];
    end
  end

  assign op_err = (op_q == '0) || ((op_q & (op_q - W'(1))) != '0);

  // Gated by rst so the grant is withdrawn the moment reset asserts.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && found) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    op_d    = op_q;
    valid_d = valid_q;
    rid_d   = rid_q;
    pow_d   = pow_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_d    = num_a[grant];
          id_d    = grant;
          rr_d    = IW'((32'(grant) + 1) % N_REQ);
          state_d = CALC;
        end
      end
      CALC: begin
        valid_d = 1'b1;
        rid_d   = id_q;
        err_d   = op_err;
        pow_d   = op_err ? '0 : gp_pow;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      rid_q   <= '0;
      pow_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      rid_q   <= rid_d;
      pow_q   <= pow_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = rid_q;
  assign rsp_pow   = pow_q;
  assign rsp_err   = err_q;

endmodule
